// File: rtl/ct_lsu_dcache_dirty_ctrl_pkg.sv
// Shared definitions for the LSU dcache dirty-array sequencer: per-config
// index widths, entry width, walk FSM encoding and the starvation default.
package ct_lsu_dcache_dirty_ctrl_pkg;

   localparam int IDX_W_32K      = 8;
   localparam int IDX_W_64K      = 9;
   localparam int DIRTY_DATA_W   = 7;
   localparam int STARVE_MAX_DEF = 7;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_WALK = 2'd2
   } walk_state_e;

endpackage

// File: rtl/ct_lsu_dcache_dirty_ctrl_if.sv
// Requester-side bundle of the dirty-array sequencer: write path, read path
// and the CP0 invalidate-all control.
//
// Handshake: a requester raises req with its index/data and holds them
// stable until it sees gnt in the same cycle; gnt is a combinational answer
// to req. A cycle with req=1 and gnt=1 is one accepted access, so keeping
// req high after gnt issues another access. cp0_inv_req is a single-cycle
// pulse that is only honoured while inv_busy=0.
interface ct_lsu_dcache_dirty_ctrl_if
   import ct_lsu_dcache_dirty_ctrl_pkg::*;
#(
   parameter int IDX_W  = IDX_W_64K,
   parameter int DATA_W = DIRTY_DATA_W
) ();

   logic              wr_req;
   logic [IDX_W-1:0]  wr_idx;
   logic [DATA_W-1:0] wr_din;
   logic [DATA_W-1:0] wr_mask;
   logic              wr_gnt;
   logic              rd_req;
   logic [IDX_W-1:0]  rd_idx;
   logic              rd_gnt;
   logic              rd_data_vld;
   logic [DATA_W-1:0] rd_data;
   logic              cp0_inv_req;
   logic              inv_busy;
   logic              inv_done;

   modport master (
      output wr_req, wr_idx, wr_din, wr_mask, rd_req, rd_idx, cp0_inv_req,
      input  wr_gnt, rd_gnt, rd_data_vld, rd_data, inv_busy, inv_done
   );

   modport slave (
      input  wr_req, wr_idx, wr_din, wr_mask, rd_req, rd_idx, cp0_inv_req,
      output wr_gnt, rd_gnt, rd_data_vld, rd_data, inv_busy, inv_done
   );

endinterface

// File: rtl/ct_lsu_dcache_dirty_walk.sv
// Index-walk engine: clears every dirty entry after reset (INIT) and on a
// CP0 invalidate-all (WALK). Tracks how long the walk has been blocked and
// forces it through once the starvation limit is reached.
module ct_lsu_dcache_dirty_walk
   import ct_lsu_dcache_dirty_ctrl_pkg::*;
#(
   parameter int IDX_W      = IDX_W_64K,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cp0_inv_req,
   input  logic             walk_gnt,
   output logic             walk_act,
   output logic             walk_force,
   output logic [IDX_W-1:0] walk_cnt,
   output logic             inv_busy,
   output logic             inv_done,
   output walk_state_e      state
);

   localparam int STARVE_W = $clog2(STARVE_MAX + 1);
   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   walk_state_e         state_nxt;
   logic [IDX_W-1:0]    cnt_nxt;
   logic [STARVE_W-1:0] starve_cnt;
   logic [STARVE_W-1:0] starve_nxt;
   logic                done_nxt;
   logic                last_idx;

   assign last_idx = &walk_cnt;

   // State, walk pointer, starvation counter and done pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_INIT;
         walk_cnt   <= '0;
         starve_cnt <= '0;
         inv_done   <= 1'b0;
      end else begin
         state      <= state_nxt;
         walk_cnt   <= cnt_nxt;
         starve_cnt <= starve_nxt;
         inv_done   <= done_nxt;
      end
   end

   // Next-state: advance the pointer on each walk grant, leave after the
   // last index, and count cycles the invalidate walk spends blocked.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = walk_cnt;
      starve_nxt = starve_cnt;
      done_nxt   = 1'b0;
      case (state)
         ST_INIT: begin
            if (walk_gnt) begin
               cnt_nxt    = walk_cnt + 1'b1;
               starve_nxt = '0;
               if (last_idx) state_nxt = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (cp0_inv_req) begin
               state_nxt  = ST_WALK;
               cnt_nxt    = '0;
               starve_nxt = '0;
            end
         end
         ST_WALK: begin
            if (walk_gnt) begin
               cnt_nxt    = walk_cnt + 1'b1;
               starve_nxt = '0;
               if (last_idx) begin
                  state_nxt = ST_IDLE;
                  done_nxt  = 1'b1;
               end
            end else begin
               starve_nxt = starve_cnt + 1'b1;
            end
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   // INIT owns the array outright; WALK only once it has starved long enough.
   assign walk_act   = (state != ST_IDLE);
   assign walk_force = (state == ST_INIT) ||
                       ((state == ST_WALK) && (starve_cnt == STARVE_LIM));
   assign inv_busy   = walk_act;

endmodule

// File: rtl/ct_lsu_dcache_dirty_ctrl.sv
// Dirty-array sequencer: arbitrates the single-port dirty SRAM between the
// write path, the read path and the walk engine, and drives every SRAM pin
// from a flop. Read data returns two cycles after the read grant.
module ct_lsu_dcache_dirty_ctrl
   import ct_lsu_dcache_dirty_ctrl_pkg::*;
#(
   parameter int IDX_W      = IDX_W_64K,
   parameter int DATA_W     = DIRTY_DATA_W,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic                      forever_cpuclk,
   input  logic                      cpurst_b,
   ct_lsu_dcache_dirty_ctrl_if.slave lsu,
   output logic                      dirty_sel_b,
   output logic                      dirty_gwen_b,
   output logic [DATA_W-1:0]         dirty_wen_b,
   output logic [IDX_W-1:0]          dirty_idx,
   output logic [DATA_W-1:0]         dirty_din,
   output logic                      dirty_gateclk_en,
   input  logic [DATA_W-1:0]         dirty_dout,
   output walk_state_e               dbg_state
);

   logic             walk_act;
   logic             walk_force;
   logic             walk_gnt;
   logic [IDX_W-1:0] walk_cnt;
   logic             wr_gnt;
   logic             rd_gnt;
   logic             any_gnt;
   logic             rd_vld_q;
   logic             rd_data_vld;
   logic             inv_busy;
   logic             inv_done;

   ct_lsu_dcache_dirty_walk #(
      .IDX_W      (IDX_W),
      .STARVE_MAX (STARVE_MAX)
   ) u_walk (
      .clk         (forever_cpuclk),
      .rst_n       (cpurst_b),
      .cp0_inv_req (lsu.cp0_inv_req),
      .walk_gnt    (walk_gnt),
      .walk_act    (walk_act),
      .walk_force  (walk_force),
      .walk_cnt    (walk_cnt),
      .inv_busy    (inv_busy),
      .inv_done    (inv_done),
      .state       (dbg_state)
   );

   // Priority wr > rd > walk, except a forced walk (INIT or starved) wins.
   assign wr_gnt   = lsu.wr_req & ~walk_force;
   assign rd_gnt   = lsu.rd_req & ~lsu.wr_req & ~walk_force;
   assign walk_gnt = walk_act & (walk_force | ~(lsu.wr_req | lsu.rd_req));
   assign any_gnt  = walk_gnt | wr_gnt | rd_gnt;

   // Register the winning access onto the SRAM pins.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         dirty_sel_b      <= 1'b1;
         dirty_gwen_b     <= 1'b1;
         dirty_wen_b      <= '1;
         dirty_idx        <= '0;
         dirty_din        <= '0;
         dirty_gateclk_en <= 1'b0;
      end else begin
         dirty_sel_b      <= ~any_gnt;
         dirty_gateclk_en <= any_gnt;
         if (walk_gnt) begin
            dirty_gwen_b <= 1'b0;
            dirty_wen_b  <= '0;
            dirty_idx    <= walk_cnt;
            dirty_din    <= '0;
         end else if (wr_gnt) begin
            dirty_gwen_b <= 1'b0;
            dirty_wen_b  <= ~lsu.wr_mask;
            dirty_idx    <= lsu.wr_idx;
            dirty_din    <= lsu.wr_din;
         end else if (rd_gnt) begin
            dirty_gwen_b <= 1'b1;
            dirty_wen_b  <= '1;
            dirty_idx    <= lsu.rd_idx;
         end else begin
            dirty_gwen_b <= 1'b1;
            dirty_wen_b  <= '1;
         end
      end
   end

   // Two-stage read-valid pipe matching pin flop plus SRAM output latency.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         rd_vld_q    <= 1'b0;
         rd_data_vld <= 1'b0;
      end else begin
         rd_vld_q    <= rd_gnt;
         rd_data_vld <= rd_vld_q;
      end
   end

   assign lsu.wr_gnt      = wr_gnt;
   assign lsu.rd_gnt      = rd_gnt;
   assign lsu.rd_data_vld = rd_data_vld;
   assign lsu.rd_data     = rd_data_vld ? dirty_dout : '0;
   assign lsu.inv_busy    = inv_busy;
   assign lsu.inv_done    = inv_done;

endmodule

// File: tb/tb_ct_lsu_dcache_dirty_ctrl.sv
// Bench for the dirty-array sequencer: behavioural SRAM, a reference model
// of array contents and arbitration rules, and a directed/random sequence.
`timescale 1ns/1ps
module tb_ct_lsu_dcache_dirty_ctrl;
   import ct_lsu_dcache_dirty_ctrl_pkg::*;

   localparam int IDX_W      = 9;
   localparam int DATA_W     = 7;
   localparam int STARVE_MAX = 7;
   localparam int DEPTH      = 1 << IDX_W;
   localparam logic [DATA_W-1:0] ONES = '1;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              dirty_sel_b;
   logic              dirty_gwen_b;
   logic [DATA_W-1:0] dirty_wen_b;
   logic [IDX_W-1:0]  dirty_idx;
   logic [DATA_W-1:0] dirty_din;
   logic              dirty_gateclk_en;
   logic [DATA_W-1:0] dirty_dout;
   walk_state_e       dbg_state;

   ct_lsu_dcache_dirty_ctrl_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) lsu_if ();

   ct_lsu_dcache_dirty_ctrl #(
      .IDX_W(IDX_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .forever_cpuclk   (clk),
      .cpurst_b         (rst_n),
      .lsu              (lsu_if),
      .dirty_sel_b      (dirty_sel_b),
      .dirty_gwen_b     (dirty_gwen_b),
      .dirty_wen_b      (dirty_wen_b),
      .dirty_idx        (dirty_idx),
      .dirty_din        (dirty_din),
      .dirty_gateclk_en (dirty_gateclk_en),
      .dirty_dout       (dirty_dout),
      .dbg_state        (dbg_state)
   );

   // Behavioural single-port SRAM: bit-masked write, registered read.
   logic [DATA_W-1:0] sram [DEPTH];
   always @(posedge clk) begin
      if (!dirty_sel_b) begin
         if (!dirty_gwen_b)
            sram[dirty_idx] <= (sram[dirty_idx] & dirty_wen_b) | (dirty_din & ~dirty_wen_b);
         else
            dirty_dout <= sram[dirty_idx];
      end
   end

   // ---------------- reference model ----------------
   int                n_assert = 0;
   int                n_fail   = 0;
   int                m_mode;      // 0: post-reset sweep, 1: idle, 2: invalidate walk
   int                m_ptr;
   int                m_starve;
   bit                m_done;
   bit                m_vld1, m_vld2;
   logic [DATA_W-1:0] m_mem [DEPTH];
   logic [DATA_W-1:0] exp_q [$];
   bit                pa_valid;
   int                pa_kind;     // 0 walk, 1 write, 2 read
   int                pa_idx;
   logic [DATA_W-1:0] pa_din;
   logic [DATA_W-1:0] pa_wen;
   logic [DATA_W-1:0] last_rd;
   int                n_done_seen = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode   = 0;
      m_ptr    = 0;
      m_starve = 0;
      m_done   = 0;
      m_vld1   = 0;
      m_vld2   = 0;
      pa_valid = 0;
      exp_q.delete();
   endtask

   task automatic chk_reset_pins(input string tag);
      chk({tag, "_sel_b"},    32'(dirty_sel_b),      32'(1));
      chk({tag, "_gwen_b"},   32'(dirty_gwen_b),     32'(1));
      chk({tag, "_wen_b"},    32'(dirty_wen_b),      32'(ONES));
      chk({tag, "_idx"},      32'(dirty_idx),        32'(0));
      chk({tag, "_din"},      32'(dirty_din),        32'(0));
      chk({tag, "_gateclk"},  32'(dirty_gateclk_en), 32'(0));
      chk({tag, "_rd_vld"},   32'(lsu_if.rd_data_vld), 32'(0));
      chk({tag, "_inv_done"}, 32'(lsu_if.inv_done),  32'(0));
      chk({tag, "_inv_busy"}, 32'(lsu_if.inv_busy),  32'(1));
   endtask

   // ---------------- driver ----------------
   task automatic drive(input bit wr, input int widx, input int wdin, input int wmask,
                        input bit rd, input int ridx, input bit cp0);
      lsu_if.wr_req      = wr;
      lsu_if.wr_idx      = widx[IDX_W-1:0];
      lsu_if.wr_din      = wdin[DATA_W-1:0];
      lsu_if.wr_mask     = wmask[DATA_W-1:0];
      lsu_if.rd_req      = rd;
      lsu_if.rd_idx      = ridx[IDX_W-1:0];
      lsu_if.cp0_inv_req = cp0;
   endtask

   task automatic drive_idle();
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   // One clock cycle: inputs are already driven just after the falling edge.
   // Check this cycle's outputs, advance the model, return at the next fall.
   task automatic tick();
      bit                wk, wg, rg, starved;
      logic [DATA_W-1:0] e;
      #1;
      chk("inv_busy",    32'(lsu_if.inv_busy),    32'(m_mode != 1));
      chk("inv_done",    32'(lsu_if.inv_done),    32'(m_done));
      if (lsu_if.inv_done) n_done_seen++;
      chk("rd_data_vld", 32'(lsu_if.rd_data_vld), 32'(m_vld2));
      if (m_vld2) begin
         e = exp_q.pop_front();
         chk("rd_data", 32'(lsu_if.rd_data), 32'(e));
         last_rd = lsu_if.rd_data;
      end else begin
         chk("rd_data_idle", 32'(lsu_if.rd_data), 32'(0));
      end
      chk("sel_b",      32'(dirty_sel_b),      32'(!pa_valid));
      chk("gateclk_en", 32'(dirty_gateclk_en), 32'(pa_valid));
      if (pa_valid) begin
         chk("dirty_idx",    32'(dirty_idx),    32'(pa_idx));
         chk("dirty_gwen_b", 32'(dirty_gwen_b), 32'(pa_kind == 2));
         chk("dirty_wen_b",  32'(dirty_wen_b),  32'(pa_wen));
         if (pa_kind != 2) chk("dirty_din", 32'(dirty_din), 32'(pa_din));
      end

      // who should win this cycle
      starved = (m_mode == 2) && (m_starve == STARVE_MAX);
      if (m_mode == 0) begin
         wk = 1; wg = 0; rg = 0;
      end else begin
         wg = lsu_if.wr_req && !starved;
         rg = lsu_if.rd_req && !lsu_if.wr_req && !starved;
         wk = (m_mode == 2) && !(wg || rg);
      end
      chk("wr_gnt", 32'(lsu_if.wr_gnt), 32'(wg));
      chk("rd_gnt", 32'(lsu_if.rd_gnt), 32'(rg));

      // array contents and next-cycle pin expectations
      pa_valid = wk || wg || rg;
      if (wk) begin
         pa_kind = 0; pa_idx = m_ptr; pa_din = '0; pa_wen = '0;
         m_mem[m_ptr] = '0;
      end else if (wg) begin
         pa_kind = 1; pa_idx = int'(lsu_if.wr_idx); pa_din = lsu_if.wr_din; pa_wen = ~lsu_if.wr_mask;
         m_mem[lsu_if.wr_idx] = (m_mem[lsu_if.wr_idx] & ~lsu_if.wr_mask) | (lsu_if.wr_din & lsu_if.wr_mask);
      end else if (rg) begin
         pa_kind = 2; pa_idx = int'(lsu_if.rd_idx); pa_wen = ONES;
         exp_q.push_back(m_mem[lsu_if.rd_idx]);
      end

      // walk progress
      m_done = 0;
      if (wk) begin
         m_starve = 0;
         if (m_ptr == DEPTH - 1) begin
            m_done = (m_mode == 2);
            m_mode = 1;
            m_ptr  = 0;
         end else begin
            m_ptr++;
         end
      end else if (m_mode == 2) begin
         m_starve++;
      end else if (m_mode == 1 && lsu_if.cp0_inv_req) begin
         m_mode   = 2;
         m_ptr    = 0;
         m_starve = 0;
      end
      m_vld2 = m_vld1;
      m_vld1 = rg;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_walk(input int budget, input bit hold_wr, input string tag);
      int n = 0;
      while (m_mode != 1 && n < budget) begin
         if (hold_wr) drive(1, $urandom_range(0, DEPTH - 1), $urandom, $urandom, 0, 0, 0);
         else drive_idle();
         tick();
         n++;
      end
      chk(tag, 32'(lsu_if.inv_busy), 32'(0));
      drive_idle();
   endtask

   task automatic run_to_ptr(input int target, input int budget);
      int n = 0;
      drive_idle();
      while (!(m_mode == 2 && m_ptr == target) && n < budget) begin
         tick();
         n++;
      end
      chk("walk_ptr_reached", 32'(m_ptr), 32'(target));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int d0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      last_rd = '0;
      drive_idle();
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk_reset_pins("por");
      @(negedge clk);
      rst_n = 1'b1;

      // post-reset sweep, then a read on the first idle cycle
      repeat (DEPTH) tick();
      chk("state_idle_after_init", 32'(dbg_state), 32'(ST_IDLE));
      drive(0, 0, 0, 0, 1, 'h1A, 0);
      tick();
      drive(1, 'h1A, 'h55, 'h7F, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 1, 'h1A, 0);
      tick();
      chk("rd_after_init", 32'(last_rd), 32'(0));
      drive_idle();
      tick();
      tick();
      chk("rd_after_wr", 32'(last_rd), 32'h55);

      // simultaneous write and read: read waits one cycle
      drive(1, 'h20, 'h0F, 'h3C, 1, 'h1A, 0);
      tick();
      drive(0, 0, 0, 0, 1, 'h20, 0);
      tick();
      drive_idle();
      repeat (3) tick();
      chk("rd_partial_mask", 32'(last_rd), 32'h0C);

      // random idle-mode traffic
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom, $urandom,
               $urandom_range(0, 1), $urandom_range(0, 15), 0);
         tick();
      end
      drive_idle();
      repeat (3) tick();

      // invalidate walk with the write path hammering the array
      d0 = n_done_seen;
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
      run_walk(8 * DEPTH + 64, 1, "contended_walk_end");
      tick();
      chk("contended_inv_done_count", 32'(n_done_seen - d0), 32'd1);
      for (int i = 0; i < 40; i++) begin
         drive(0, 0, 0, 0, 1, $urandom_range(0, DEPTH - 1), 0);
         tick();
      end
      drive_idle();
      repeat (3) tick();

      // cp0 pulse during a walk is dropped
      d0 = n_done_seen;
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
      run_to_ptr(100, 2 * DEPTH);
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
      run_walk(2 * DEPTH, 0, "walk_a_end");
      repeat (4) tick();
      chk("single_inv_done", 32'(n_done_seen - d0), 32'd1);

      // reset in the middle of a walk
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
      run_to_ptr(200, 2 * DEPTH);
      rst_n = 1'b0;
      #1;
      chk_reset_pins("midwalk_rst");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (DEPTH) tick();
      chk("inv_busy_after_reinit", 32'(lsu_if.inv_busy), 32'(0));

      // writes on both sides of the walk pointer
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
      run_to_ptr(10, 2 * DEPTH);
      drive(1, 300, 'h2A, 'h7F, 0, 0, 0);
      tick();
      drive(1, 5, 'h33, 'h7F, 0, 0, 0);
      tick();
      run_walk(2 * DEPTH, 0, "walk_c_end");
      tick();
      drive(0, 0, 0, 0, 1, 300, 0);
      tick();
      drive(0, 0, 0, 0, 1, 5, 0);
      tick();
      drive_idle();
      tick();
      chk("rd_idx300_cleared", 32'(last_rd), 32'h00);
      tick();
      chk("rd_idx5_survives", 32'(last_rd), 32'h33);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #2000000;
      $display("FAIL global_timeout: observed=stalled expected=finished");
      $fatal(1, "timeout");
   end

endmodule
